// File: rtl/branch_predictor_pkg.sv
// Shared decode constants and PC-source encodings for the branch predictor and resolver.
// Pure declarations: no logic, no latency, no flow control.
package branch_predictor_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_BAL  = 6'h01;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLEZ = 6'h06;
  localparam logic [5:0] OP_BGTZ = 6'h07;

  localparam logic [5:0] FUNC_JR   = 6'h08;
  localparam logic [5:0] FUNC_JALR = 6'h09;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_J   = 2'b01,
    PCSRC_BR  = 2'b10,
    PCSRC_JR  = 2'b11
  } pc_src_e;

  // Widths follow the default predictor geometry (32-bit PC, 16 entries, 2-bit counters).
  localparam int BTB_ADDR_W = 32;
  localparam int BTB_IDX_W  = 4;
  localparam int BTB_TAG_W  = BTB_ADDR_W - BTB_IDX_W - 2;
  localparam int BTB_CTR_W  = 2;

  typedef struct packed {
    logic                  valid;
    logic                  uncond;
    logic [BTB_TAG_W-1:0]  tag;
    logic [BTB_ADDR_W-1:0] target;
    logic [BTB_CTR_W-1:0]  ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_resolve.sv
// Combinational EX-stage control-transfer decode: pc_src, CTI flag and actual target.
// Zero latency, no state, no backpressure.
module branch_resolve
  import branch_predictor_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_valid,
  input  logic [5:0]        i_op,
  input  logic [4:0]        i_rt_field,
  input  logic [5:0]        i_func,
  input  logic [DATA_W-1:0] i_rs,
  input  logic [DATA_W-1:0] i_rt,
  input  logic [ADDR_W-1:0] i_br_target,
  input  logic [ADDR_W-1:0] i_j_target,
  output logic [1:0]        o_pc_src,
  output logic              o_is_cti,
  output logic [ADDR_W-1:0] o_act_target
);

  logic    w_rs_neg;
  logic    w_rs_zero;
  logic    w_rs_eq_rt;
  pc_src_e w_pc_src;
  logic    w_is_cti;

  assign w_rs_neg   = i_rs[DATA_W-1];
  assign w_rs_zero  = (i_rs == '0);
  assign w_rs_eq_rt = (i_rs == i_rt);

  always_comb begin
    w_pc_src = PCSRC_SEQ;
    w_is_cti = 1'b0;
    if (i_valid) begin
      case (i_op)
        OP_R: begin
          if (i_func == FUNC_JR || i_func == FUNC_JALR) begin
            w_is_cti = 1'b1;
            w_pc_src = PCSRC_JR;
          end
        end
        OP_BAL: begin
          case (i_rt_field)
            RT_BLTZ, RT_BLTZAL: begin
              w_is_cti = 1'b1;
              if (w_rs_neg) w_pc_src = PCSRC_BR;
            end
            RT_BGEZ, RT_BGEZAL: begin
              w_is_cti = 1'b1;
              if (!w_rs_neg) w_pc_src = PCSRC_BR;
            end
            default: ;
          endcase
        end
        OP_J, OP_JAL: begin
          w_is_cti = 1'b1;
          w_pc_src = PCSRC_J;
        end
        OP_BEQ: begin
          w_is_cti = 1'b1;
          if (w_rs_eq_rt) w_pc_src = PCSRC_BR;
        end
        OP_BNE: begin
          w_is_cti = 1'b1;
          if (!w_rs_eq_rt) w_pc_src = PCSRC_BR;
        end
        OP_BLEZ: begin
          w_is_cti = 1'b1;
          if (w_rs_neg || w_rs_zero) w_pc_src = PCSRC_BR;
        end
        OP_BGTZ: begin
          w_is_cti = 1'b1;
          if (!w_rs_neg && !w_rs_zero) w_pc_src = PCSRC_BR;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (w_pc_src)
      PCSRC_BR: o_act_target = i_br_target;
      PCSRC_J:  o_act_target = i_j_target;
      PCSRC_JR: o_act_target = ADDR_W'(i_rs);
      default:  o_act_target = '0;
    endcase
  end

  assign o_pc_src = w_pc_src;
  assign o_is_cti = w_is_cti;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB predictor: 0-cycle IF lookup, 0-cycle EX resolve/redirect, update visible next cycle.
// No handshake; i_ex_stall freezes all BTB and counter state.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_if_valid,
  input  logic [ADDR_W-1:0] i_if_pc,
  output logic              o_pred_taken,
  output logic [ADDR_W-1:0] o_pred_target,
  input  logic              i_ex_valid,
  input  logic              i_ex_stall,
  input  logic [ADDR_W-1:0] i_ex_pc,
  input  logic [5:0]        i_ex_op,
  input  logic [4:0]        i_ex_rt_field,
  input  logic [5:0]        i_ex_func,
  input  logic [DATA_W-1:0] i_ex_rs,
  input  logic [DATA_W-1:0] i_ex_rt,
  input  logic [ADDR_W-1:0] i_ex_br_target,
  input  logic [ADDR_W-1:0] i_ex_j_target,
  input  logic              i_ex_pred_taken,
  input  logic [ADDR_W-1:0] i_ex_pred_target,
  output logic [1:0]        o_pc_src,
  output logic              o_mispredict,
  output logic [ADDR_W-1:0] o_redirect_pc,
  output logic [CNT_W-1:0]  o_br_count,
  output logic [CNT_W-1:0]  o_mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = ~CTR_WT;

  // Same layout as the package btb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic              valid;
    logic              uncond;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CTR_W-1:0]  ctr;
  } entry_t;

  entry_t           r_btb [ENTRIES];
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_mispred_count;

  logic [IDX_W-1:0]  w_if_idx;
  logic [TAG_W-1:0]  w_if_tag;
  entry_t            w_if_ent;
  logic              w_if_hit;
  logic              w_unused_pc_lsb;

  logic [1:0]        w_pc_src;
  logic              w_is_cti;
  logic [ADDR_W-1:0] w_act_target;
  logic              w_act_taken;
  logic              w_mispredict;
  logic              w_upd;
  logic              w_btb_wr;

  logic [IDX_W-1:0]  w_ex_idx;
  logic [TAG_W-1:0]  w_ex_tag;
  entry_t            w_ex_ent;
  entry_t            w_ex_new;
  logic              w_ex_hit;
  logic              w_ex_we;

  assign w_if_idx        = i_if_pc[IDX_W+1:2];
  assign w_if_tag        = i_if_pc[ADDR_W-1:IDX_W+2];
  assign w_if_ent        = r_btb[w_if_idx];
  assign w_if_hit        = i_if_valid && w_if_ent.valid && (w_if_ent.tag == w_if_tag);
  assign o_pred_taken    = w_if_hit && (w_if_ent.uncond || w_if_ent.ctr[CTR_W-1]);
  assign o_pred_target   = o_pred_taken ? w_if_ent.target : '0;
  assign w_unused_pc_lsb = &{1'b0, i_if_pc[1:0]};

  branch_resolve #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_resolve (
    .i_valid      (i_ex_valid),
    .i_op         (i_ex_op),
    .i_rt_field   (i_ex_rt_field),
    .i_func       (i_ex_func),
    .i_rs         (i_ex_rs),
    .i_rt         (i_ex_rt),
    .i_br_target  (i_ex_br_target),
    .i_j_target   (i_ex_j_target),
    .o_pc_src     (w_pc_src),
    .o_is_cti     (w_is_cti),
    .o_act_target (w_act_target)
  );

  // A non-CTI arriving with a stale taken prediction is caught by the first term.
  assign w_act_taken   = (w_pc_src != PCSRC_SEQ);
  assign w_mispredict  = i_ex_valid &&
                         ((w_act_taken != i_ex_pred_taken) ||
                          (w_act_taken && (w_act_target != i_ex_pred_target)));
  assign o_mispredict  = w_mispredict;
  assign o_pc_src      = w_pc_src;
  assign o_redirect_pc = w_act_taken ? w_act_target : (i_ex_pc + ADDR_W'(4));

  assign w_upd    = i_ex_valid && !i_ex_stall;
  assign w_btb_wr = w_upd && w_is_cti;
  assign w_ex_idx = i_ex_pc[IDX_W+1:2];
  assign w_ex_tag = i_ex_pc[ADDR_W-1:IDX_W+2];
  assign w_ex_ent = r_btb[w_ex_idx];
  assign w_ex_hit = w_ex_ent.valid && (w_ex_ent.tag == w_ex_tag);
  assign w_ex_we  = w_btb_wr && (w_ex_hit || w_act_taken);

  always_comb begin
    w_ex_new = w_ex_ent;
    if (w_ex_hit) begin
      if (w_act_taken) begin
        if (w_ex_ent.ctr != CTR_MAX) w_ex_new.ctr = w_ex_ent.ctr + CTR_W'(1);
        w_ex_new.target = w_act_target;
      end else if (w_ex_ent.ctr != '0) begin
        w_ex_new.ctr = w_ex_ent.ctr - CTR_W'(1);
      end
    end else begin
      w_ex_new.valid  = 1'b1;
      w_ex_new.uncond = (w_pc_src == PCSRC_J) || (w_pc_src == PCSRC_JR);
      w_ex_new.tag    = w_ex_tag;
      w_ex_new.target = w_act_target;
      w_ex_new.ctr    = CTR_WT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_btb[i] <= '{valid: 1'b0, uncond: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else begin
      if (w_ex_we) r_btb[w_ex_idx] <= w_ex_new;
      if (w_btb_wr) r_br_count <= r_br_count + CNT_W'(1);
      if (w_upd && w_mispredict) r_mispred_count <= r_mispred_count + CNT_W'(1);
    end
  end

  assign o_br_count      = r_br_count;
  assign o_mispred_count = r_mispred_count;

endmodule
